// File: rtl/rv_core_pkg.sv
// Shared RV32I core types: fetch FSM states, the canonical NOP and the
// major opcodes decoded by main control.
package rv_core_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} fetch_state_t;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory handshake plus the retire/redirect
// interface toward main control and execute.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [6:0]      opcode_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_target_i;
    logic            fetch_err_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o,
               pc_o, pc_plus4_o, fetch_err_o,
        input  imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i,
               redirect_target_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o,
               pc_o, pc_plus4_o, fetch_err_o,
        output imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i,
               redirect_target_i
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC select on retire and a sticky misaligned-target
// error flag.
module fetch_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            retire,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic            err
);
    assign pc_plus4   = pc + XLEN'(4);
    assign misaligned = redirect && (target[1:0] != 2'b00);

    // A misaligned redirect freezes the PC at the offending instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            err <= 1'b0;
        end else if (retire) begin
            if (misaligned)    err <= 1'b1;
            else if (redirect) pc  <= target;
            else               pc  <= pc_plus4;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Non-speculative single-outstanding instruction fetch: request, hold the
// word until retire, then advance or redirect the PC.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    fetch_state_t    state_q, state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc, pc_plus4;
    logic            retire, misaligned, err;

    assign retire = (state_q == HOLD) && bus.instr_ready_i;

    fetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .retire     (retire),
        .redirect   (bus.redirect_i),
        .target     (bus.redirect_target_i),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned),
        .err        (err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= NOP_INSN;
        end else begin
            state_q <= state_d;
            if (state_q == REQ && bus.imem_rvalid_i) instr_q <= bus.imem_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (bus.imem_rvalid_i) state_d = HOLD;
            HOLD:    if (retire) state_d = misaligned ? ERR : REQ;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registered state, never from imem_rdata_i.
    assign bus.imem_req_o    = (state_q == REQ);
    assign bus.imem_addr_o   = pc;
    assign bus.instr_valid_o = (state_q == HOLD);
    assign bus.instr_o       = bus.instr_valid_o ? instr_q : NOP_INSN;
    assign bus.opcode_o      = bus.instr_o[6:0];
    assign bus.pc_o          = pc;
    assign bus.pc_plus4_o    = pc_plus4;
    assign bus.fetch_err_o   = err;
endmodule
